// File: rtl/branch_predict_ctrl_pkg.sv
// Shared constants and types for the branch predictor / redirect controller.
// Opcode classes, 2-bit counter states, BTB write operations and FSM states.
package branch_predict_ctrl_pkg;

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_BRANCH,
        CLS_JUMP
    } ctrl_class_t;

    typedef enum logic [1:0] {
        BTB_WR_BRANCH,
        BTB_WR_JUMP,
        BTB_WR_INVAL
    } btb_wr_op_t;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    function automatic ctrl_class_t classify(input logic [4:0] opc);
        ctrl_class_t cls;
        case (opc)
            OPC_BRANCH:        cls = CLS_BRANCH;
            OPC_JAL, OPC_JALR: cls = CLS_JUMP;
            default:           cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// One combinational read port (no write bypass) and one synchronous write port.
module btb_table
    import branch_predict_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [XLEN-1:0] rd_pc_i,
    output logic            rd_taken_o,
    output logic [XLEN-1:0] rd_target_o,
    input  logic            wr_en_i,
    input  btb_wr_op_t      wr_op_i,
    input  logic [XLEN-1:0] wr_pc_i,
    input  logic [XLEN-1:0] wr_target_i,
    input  logic            wr_taken_i
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = XLEN - INDEX_BITS - 2;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    ctr_t                ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_BITS-1:0]   rd_tag, wr_tag;
    logic                  rd_hit, wr_hit;
    logic                  wr_valid_d;
    ctr_t                  wr_ctr_d;

    // Instructions are word aligned, so the two low PC bits never select anything.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

    assign rd_idx = rd_pc_i[INDEX_BITS+1:2];
    assign rd_tag = rd_pc_i[XLEN-1:INDEX_BITS+2];
    assign wr_idx = wr_pc_i[INDEX_BITS+1:2];
    assign wr_tag = wr_pc_i[XLEN-1:INDEX_BITS+2];

    function automatic ctr_t sat_update(input ctr_t cur, input logic taken);
        logic [1:0] raw;
        raw = cur;
        if (taken) begin
            raw = (cur == ST) ? 2'b11 : raw + 2'd1;
        end else begin
            raw = (cur == SNT) ? 2'b00 : raw - 2'd1;
        end
        return ctr_t'(raw);
    endfunction

    always_comb begin
        rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_taken_o  = rd_hit && ctr_q[rd_idx][1];
        rd_target_o = rd_taken_o ? target_q[rd_idx] : '0;
    end

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        wr_hit     = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
        wr_valid_d = 1'b1;
        wr_ctr_d   = ctr_q[wr_idx];
        case (wr_op_i)
            BTB_WR_BRANCH: wr_ctr_d = wr_hit ? sat_update(ctr_q[wr_idx], wr_taken_i)
                                             : (wr_taken_i ? WT : WNT);
            BTB_WR_JUMP:   wr_ctr_d = ST;
            default:       wr_valid_d = 1'b0;
        endcase
    end

    // NOTE: the arrays are reset explicitly because a stale valid bit would predict garbage.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (wr_en_i) begin
            valid_q[wr_idx] <= wr_valid_d;
            if (wr_op_i != BTB_WR_INVAL) begin
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= wr_target_i;
                ctr_q[wr_idx]    <= wr_ctr_d;
            end
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction and redirect controller: BTB lookup for IF, EX-stage
// mispredict detection, registered redirect, multi-cycle flush and perf counters.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BTB_INDEX_BITS = 6,
    parameter int FLUSH_CYCLES   = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [XLEN-1:0] fetch_pc_in,
    output logic            pred_taken_out,
    output logic [XLEN-1:0] pred_target_out,
    input  logic            ex_valid_in,
    input  logic [XLEN-1:0] ex_pc_in,
    input  logic [4:0]      ex_opcode_6_to_2_in,
    input  logic            ex_pred_taken_in,
    input  logic [XLEN-1:0] ex_pred_target_in,
    input  logic            ex_branch_taken_in,
    input  logic [XLEN-1:0] ex_target_in,
    output logic            redirect_valid_out,
    output logic [XLEN-1:0] redirect_pc_out,
    output logic            flush_out,
    output logic [31:0]     branch_count_out,
    output logic [31:0]     mispredict_count_out
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_t          state_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            flush_q;
    logic [31:0]     branch_count_q, branch_count_d;
    logic [31:0]     mispredict_count_q, mispredict_count_d;

    ctrl_class_t     ex_class;
    logic            is_ctrl;
    logic            actual_taken;
    logic            resolve;
    logic            mispredict;
    logic [XLEN-1:0] correct_pc_d;
    logic            btb_wr_en;
    btb_wr_op_t      btb_wr_op;

    always_comb begin
        ex_class     = classify(ex_opcode_6_to_2_in);
        is_ctrl      = (ex_class != CLS_NONE);
        actual_taken = (ex_class == CLS_JUMP) ||
                       ((ex_class == CLS_BRANCH) && ex_branch_taken_in);
        resolve      = ex_valid_in && (state_q == ST_IDLE);
        mispredict   = resolve &&
                       ((ex_pred_taken_in != actual_taken) ||
                        (actual_taken && (ex_pred_target_in != ex_target_in)));
        correct_pc_d = actual_taken ? ex_target_in : ex_pc_in + XLEN'(4);

        // A non-control instruction only touches the BTB when it aliased to a taken entry.
        btb_wr_en = resolve && (is_ctrl || ex_pred_taken_in);
        case (ex_class)
            CLS_BRANCH: btb_wr_op = BTB_WR_BRANCH;
            CLS_JUMP:   btb_wr_op = BTB_WR_JUMP;
            default:    btb_wr_op = BTB_WR_INVAL;
        endcase

        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (resolve && is_ctrl && (branch_count_q != '1)) begin
            branch_count_d = branch_count_q + 32'd1;
        end
        if (mispredict && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    btb_table #(
        .XLEN       (XLEN),
        .INDEX_BITS (BTB_INDEX_BITS)
    ) u_btb (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rd_pc_i     (fetch_pc_in),
        .rd_taken_o  (pred_taken_out),
        .rd_target_o (pred_target_out),
        .wr_en_i     (btb_wr_en),
        .wr_op_i     (btb_wr_op),
        .wr_pc_i     (ex_pc_in),
        .wr_target_i (ex_target_in),
        .wr_taken_i  (actual_taken)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q          <= ST_IDLE;
            flush_cnt_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
        end else begin
            redirect_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mispredict) begin
                        state_q          <= ST_FLUSH;
                        flush_cnt_q      <= CNT_W'(FLUSH_CYCLES - 1);
                        flush_q          <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= correct_pc_d;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign redirect_valid_out   = redirect_valid_q;
    assign redirect_pc_out      = redirect_pc_q;
    assign flush_out            = flush_q;
    assign branch_count_out     = branch_count_q;
    assign mispredict_count_out = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed vector table, corner
// sequences (reset mid-flush, counter saturation) and a randomized model run.
module tb_branch_predict_ctrl;
    import branch_predict_ctrl_pkg::*;

    localparam int FLUSH = 2;
    localparam logic [4:0] OPC_ADDI = 5'b00100;
    localparam logic [4:0] OPC_ADD  = 5'b01100;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] fetch_pc_in;
    logic        pred_taken_out;
    logic [31:0] pred_target_out;
    logic        ex_valid_in;
    logic [31:0] ex_pc_in;
    logic [4:0]  ex_opcode_6_to_2_in;
    logic        ex_pred_taken_in;
    logic [31:0] ex_pred_target_in;
    logic        ex_branch_taken_in;
    logic [31:0] ex_target_in;
    logic        redirect_valid_out;
    logic [31:0] redirect_pc_out;
    logic        flush_out;
    logic [31:0] branch_count_out;
    logic [31:0] mispredict_count_out;

    always #5 clk_in = ~clk_in;

    branch_predict_ctrl #(
        .XLEN           (32),
        .BTB_INDEX_BITS (6),
        .FLUSH_CYCLES   (FLUSH)
    ) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .fetch_pc_in          (fetch_pc_in),
        .pred_taken_out       (pred_taken_out),
        .pred_target_out      (pred_target_out),
        .ex_valid_in          (ex_valid_in),
        .ex_pc_in             (ex_pc_in),
        .ex_opcode_6_to_2_in  (ex_opcode_6_to_2_in),
        .ex_pred_taken_in     (ex_pred_taken_in),
        .ex_pred_target_in    (ex_pred_target_in),
        .ex_branch_taken_in   (ex_branch_taken_in),
        .ex_target_in         (ex_target_in),
        .redirect_valid_out   (redirect_valid_out),
        .redirect_pc_out      (redirect_pc_out),
        .flush_out            (flush_out),
        .branch_count_out     (branch_count_out),
        .mispredict_count_out (mispredict_count_out)
    );

    typedef struct {
        logic [31:0] fpc;
        logic        exv;
        logic [31:0] expc;
        logic [4:0]  opc;
        logic        ptk;
        logic [31:0] ptgt;
        logic        btk;
        logic [31:0] tgt;
        logic        e_ptk;
        logic [31:0] e_ptgt;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_fl;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [31:0] fpc, input logic exv, input logic [31:0] expc, input logic [4:0] opc,
        input logic ptk, input logic [31:0] ptgt, input logic btk, input logic [31:0] tgt,
        input logic e_ptk, input logic [31:0] e_ptgt, input logic e_rv, input logic [31:0] e_rpc,
        input logic e_fl, input logic [31:0] e_bc, input logic [31:0] e_mc);
        vec_t v;
        v.fpc = fpc; v.exv = exv; v.expc = expc; v.opc = opc;
        v.ptk = ptk; v.ptgt = ptgt; v.btk = btk; v.tgt = tgt;
        v.e_ptk = e_ptk; v.e_ptgt = e_ptgt; v.e_rv = e_rv; v.e_rpc = e_rpc;
        v.e_fl = e_fl; v.e_bc = e_bc; v.e_mc = e_mc;
        return v;
    endfunction

    // Drives one cycle of inputs, checks the lookup before the edge and the
    // registered outputs just after it.
    task automatic apply(input vec_t v, input string name);
        fetch_pc_in         = v.fpc;
        ex_valid_in         = v.exv;
        ex_pc_in            = v.expc;
        ex_opcode_6_to_2_in = v.opc;
        ex_pred_taken_in    = v.ptk;
        ex_pred_target_in   = v.ptgt;
        ex_branch_taken_in  = v.btk;
        ex_target_in        = v.tgt;
        #2;
        check({name, " pred_taken"},  32'(pred_taken_out), 32'(v.e_ptk));
        check({name, " pred_target"}, pred_target_out, v.e_ptgt);
        @(posedge clk_in);
        #1;
        check({name, " redirect_valid"}, 32'(redirect_valid_out), 32'(v.e_rv));
        check({name, " redirect_pc"},    redirect_pc_out, v.e_rpc);
        check({name, " flush"},          32'(flush_out), 32'(v.e_fl));
        check({name, " branch_count"},   branch_count_out, v.e_bc);
        check({name, " mispred_count"},  mispredict_count_out, v.e_mc);
    endtask

    task automatic do_reset();
        rst_in              = 1'b1;
        fetch_pc_in         = '0;
        ex_valid_in         = 1'b0;
        ex_pc_in            = '0;
        ex_opcode_6_to_2_in = '0;
        ex_pred_taken_in    = 1'b0;
        ex_pred_target_in   = '0;
        ex_branch_taken_in  = 1'b0;
        ex_target_in        = '0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    // Behavioural reference: plain arrays indexed by integer arithmetic on the PC.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    int          m_flush_left;
    logic [31:0] m_rpc;
    longint      m_bc, m_mc;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_flush_left = 0; m_rpc = '0; m_bc = 0; m_mc = 0;
    endtask

    task automatic model_step(inout vec_t v);
        int unsigned idx, tg;
        bit is_br, is_j, actual, mis;
        idx = (v.fpc >> 2) % 64;
        tg  = v.fpc >> 8;
        v.e_ptk  = m_valid[idx] && (m_tag[idx] == tg) && (m_ctr[idx] >= 2);
        v.e_ptgt = v.e_ptk ? m_tgt[idx] : 32'h0;
        mis = 0;
        if (v.exv && m_flush_left == 0) begin
            is_br  = (v.opc == OPC_BRANCH);
            is_j   = (v.opc == OPC_JAL) || (v.opc == OPC_JALR);
            actual = is_br ? v.btk : is_j;
            mis    = (v.ptk != actual) || (v.ptk && actual && v.ptgt != v.tgt);
            if ((is_br || is_j) && m_bc < 64'hFFFF_FFFF) m_bc++;
            if (mis) begin
                if (m_mc < 64'hFFFF_FFFF) m_mc++;
                m_rpc = actual ? v.tgt : v.expc + 32'd4;
            end
            idx = (v.expc >> 2) % 64;
            tg  = v.expc >> 8;
            if (is_br) begin
                if (m_valid[idx] && m_tag[idx] == tg)
                    m_ctr[idx] = v.btk ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                                       : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
                else
                    m_ctr[idx] = v.btk ? 2 : 1;
            end else if (is_j) begin
                m_ctr[idx] = 3;
            end
            if (is_br || is_j) begin
                m_valid[idx] = 1; m_tag[idx] = tg; m_tgt[idx] = v.tgt;
            end else if (v.ptk) begin
                m_valid[idx] = 0;
            end
        end
        if (m_flush_left > 0) m_flush_left--;
        if (mis) m_flush_left = FLUSH;
        v.e_rv  = mis;
        v.e_rpc = m_rpc;
        v.e_fl  = (m_flush_left > 0);
        v.e_bc  = m_bc[31:0];
        v.e_mc  = m_mc[31:0];
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t v;
        int unsigned ridx;
        logic [4:0] opcs [6];

        // fpc exv expc opc ptk ptgt btk tgt | e_ptk e_ptgt e_rv e_rpc e_fl e_bc e_mc
        tbl.push_back(mk(32'h100, 0, 32'h0, OPC_ADDI, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(32'h100, 1, 32'h100, OPC_BRANCH, 0, 32'h0, 1, 32'h140, 0, 32'h0, 1, 32'h140, 1, 1, 1));
        tbl.push_back(mk(32'h100, 0, 32'h0, OPC_ADDI, 0, 32'h0, 0, 32'h0, 1, 32'h140, 0, 32'h140, 1, 1, 1));
        tbl.push_back(mk(32'h100, 0, 32'h0, OPC_ADDI, 0, 32'h0, 0, 32'h0, 1, 32'h140, 0, 32'h140, 0, 1, 1));
        tbl.push_back(mk(32'h100, 1, 32'h100, OPC_BRANCH, 1, 32'h140, 1, 32'h140, 1, 32'h140, 0, 32'h140, 0, 2, 1));
        tbl.push_back(mk(32'h100, 1, 32'h100, OPC_BRANCH, 1, 32'h140, 1, 32'h140, 1, 32'h140, 0, 32'h140, 0, 3, 1));
        tbl.push_back(mk(32'h100, 1, 32'h100, OPC_BRANCH, 1, 32'h140, 1, 32'h140, 1, 32'h140, 0, 32'h140, 0, 4, 1));
        tbl.push_back(mk(32'h100, 1, 32'h100, OPC_BRANCH, 1, 32'h140, 0, 32'h140, 1, 32'h140, 1, 32'h104, 1, 5, 2));
        tbl.push_back(mk(32'h100, 0, 32'h0, OPC_ADDI, 0, 32'h0, 0, 32'h0, 1, 32'h140, 0, 32'h104, 1, 5, 2));
        tbl.push_back(mk(32'h200, 0, 32'h0, OPC_ADDI, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h104, 0, 5, 2));
        tbl.push_back(mk(32'h200, 1, 32'h200, OPC_JALR, 1, 32'h300, 1, 32'h380, 0, 32'h0, 1, 32'h380, 1, 6, 3));
        tbl.push_back(mk(32'h200, 1, 32'h100, OPC_BRANCH, 0, 32'h0, 1, 32'h999, 1, 32'h380, 0, 32'h380, 1, 6, 3));
        tbl.push_back(mk(32'h100, 1, 32'h100, OPC_BRANCH, 0, 32'h0, 1, 32'h999, 0, 32'h0, 0, 32'h380, 0, 6, 3));
        tbl.push_back(mk(32'h10, 1, 32'h10, OPC_JAL, 0, 32'h0, 1, 32'h80, 0, 32'h0, 1, 32'h80, 1, 7, 4));
        tbl.push_back(mk(32'h110, 0, 32'h0, OPC_ADDI, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h80, 1, 7, 4));
        tbl.push_back(mk(32'h10, 0, 32'h0, OPC_ADDI, 0, 32'h0, 0, 32'h0, 1, 32'h80, 0, 32'h80, 0, 7, 4));
        tbl.push_back(mk(32'h10, 1, 32'h10, OPC_ADDI, 1, 32'h80, 0, 32'h0, 1, 32'h80, 1, 32'h14, 1, 7, 5));
        tbl.push_back(mk(32'h10, 0, 32'h0, OPC_ADDI, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h14, 1, 7, 5));
        tbl.push_back(mk(32'h200, 0, 32'h0, OPC_ADDI, 0, 32'h0, 0, 32'h0, 1, 32'h380, 0, 32'h14, 0, 7, 5));
        tbl.push_back(mk(32'h1f0, 1, 32'h300, OPC_ADDI, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h14, 0, 7, 5));
        tbl.push_back(mk(32'h1f0, 1, 32'hFFFF_FFFC, OPC_BRANCH, 1, 32'h40, 0, 32'h40, 0, 32'h0, 1, 32'h0, 1, 8, 6));
        tbl.push_back(mk(32'hFFFF_FFFC, 0, 32'h0, OPC_ADDI, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 8, 6));
        tbl.push_back(mk(32'hFFFF_FFFC, 0, 32'h0, OPC_ADDI, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 8, 6));

        do_reset();
        check("reset redirect_valid", 32'(redirect_valid_out), 32'h0);
        check("reset flush", 32'(flush_out), 32'h0);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Reset asserted in the middle of a flush aborts it and clears the BTB.
        do_reset();
        apply(mk(32'h100, 1, 32'h100, OPC_BRANCH, 0, 32'h0, 1, 32'h140, 0, 32'h0, 1, 32'h140, 1, 1, 1), "rstflush");
        ex_valid_in = 1'b0;
        #1;
        check("rstflush btb_before", 32'(pred_taken_out), 32'h1);
        rst_in = 1'b1;
        #1;
        check("rstflush flush", 32'(flush_out), 32'h0);
        check("rstflush redirect_valid", 32'(redirect_valid_out), 32'h0);
        check("rstflush redirect_pc", redirect_pc_out, 32'h0);
        check("rstflush mispred_count", mispredict_count_out, 32'h0);
        check("rstflush btb_cleared", 32'(pred_taken_out), 32'h0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Mispredict counter holds at all-ones.
        do_reset();
        force dut.mispredict_count_q = 32'hFFFF_FFFF;
        @(posedge clk_in);
        #1;
        release dut.mispredict_count_q;
        #1;
        check("sat preload", mispredict_count_out, 32'hFFFF_FFFF);
        apply(mk(32'h100, 1, 32'h100, OPC_BRANCH, 0, 32'h0, 1, 32'h140, 0, 32'h0, 1, 32'h140, 1, 1, 32'hFFFF_FFFF), "sat");

        // Randomized traffic against the reference model.
        opcs[0] = OPC_BRANCH; opcs[1] = OPC_BRANCH; opcs[2] = OPC_JAL;
        opcs[3] = OPC_JALR;   opcs[4] = OPC_ADDI;   opcs[5] = OPC_ADD;
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            v.fpc  = rand_pc();
            v.exv  = ($urandom_range(0, 4) != 0);
            v.expc = rand_pc();
            v.opc  = opcs[$urandom_range(0, 5)];
            v.btk  = $urandom_range(0, 1) == 1;
            v.tgt  = 32'($urandom_range(0, 15)) << 4;
            if ($urandom_range(0, 3) != 0) begin
                ridx   = (v.expc >> 2) % 64;
                v.ptk  = m_valid[ridx] && (m_tag[ridx] == (v.expc >> 8)) && (m_ctr[ridx] >= 2);
                v.ptgt = v.ptk ? m_tgt[ridx] : 32'h0;
            end else begin
                v.ptk  = $urandom_range(0, 1) == 1;
                v.ptgt = 32'($urandom_range(0, 15)) << 4;
            end
            model_step(v);
            apply(v, $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
